// File: rtl/ltl_nfa_pkg.sv
// ltl_nfa_pkg: shared definitions for the runtime-programmable NFA engine.
//   cfg_kind_e      : configuration write selector (range lo/hi, edge mask, flags)
//   FLAG_*          : bit positions inside a kind-3 (flags) write word
// The report-entry struct {idx, vec} depends on the engine parameters, so it
// is declared inside ltl_nfa_report_fifo where those widths are known.
package ltl_nfa_pkg;

  typedef enum logic [1:0] {
    CFG_RANGE_LO = 2'd0,
    CFG_RANGE_HI = 2'd1,
    CFG_EDGE     = 2'd2,
    CFG_FLAGS    = 2'd3
  } cfg_kind_e;

  // flags word layout: {report, start_all, start_sod}
  localparam int unsigned FLAG_START_SOD = 0;
  localparam int unsigned FLAG_START_ALL = 1;
  localparam int unsigned FLAG_REPORT    = 2;

endpackage

// File: rtl/ltl_nfa_if.sv
// ltl_nfa_if: report drain channel of the NFA engine (valid/ready).
//   report_valid : FIFO head valid           (engine -> consumer)
//   report_vec   : head report bitmap        (engine -> consumer)
//   report_idx   : head symbol index         (engine -> consumer)
//   report_ready : consumer accepts the head (consumer -> engine)
interface ltl_nfa_if #(
  parameter int unsigned NUM_STATES = 16,
  parameter int unsigned CNT_W      = 32
);
  logic                  report_valid;
  logic                  report_ready;
  logic [NUM_STATES-1:0] report_vec;
  logic [CNT_W-1:0]      report_idx;

  modport master (output report_valid, output report_vec, output report_idx,
                  input  report_ready);
  modport slave  (input  report_valid, input  report_vec, input  report_idx,
                  output report_ready);
endinterface

// File: rtl/ltl_nfa_report_fifo.sv
// ltl_nfa_report_fifo: synchronous valid/ready FIFO of report entries.
//   clk, reset          : clock, synchronous active-high reset
//   push, push_idx/vec  : write request and entry fields
//   ready               : consumer accepts head (pop = valid & ready)
//   valid, head_idx/vec : head entry, fields forced to 0 when empty
//   overflow            : sticky, set when a push is dropped on full
module ltl_nfa_report_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned VEC_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [CNT_W-1:0] push_idx,
  input  logic [VEC_W-1:0] push_vec,
  input  logic             ready,
  output logic             valid,
  output logic [CNT_W-1:0] head_idx,
  output logic [VEC_W-1:0] head_vec,
  output logic             overflow
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic [VEC_W-1:0] vec;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, pop, do_push;

  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop     = valid & ready;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= '{idx: push_idx, vec: push_vec};
  end

  assign head     = mem[rd_ptr];
  assign head_idx = valid ? head.idx : '0;
  assign head_vec = valid ? head.vec : '0;

endmodule

// File: rtl/ltl_nfa_engine.sv
// ltl_nfa_engine: runtime-programmable homogeneous NFA engine.
//   clk, reset   : clock, synchronous active-high reset
//   run, symbols : symbol-valid strobe and input symbol
//   cfg_*        : configuration write port (kind/state/range/data)
//   report_now   : active_q & report_mask
//   rpt          : report FIFO drain (valid/ready, vec, idx)
//   overflow     : sticky, a report entry was dropped
// Optional: define LTL_NFA_ALL_INPUT_EN to store the start_all flag;
// otherwise start_all reads as 0 and has no storage.
module ltl_nfa_engine import ltl_nfa_pkg::*; #(
  parameter int unsigned NUM_STATES   = 16,
  parameter int unsigned SYMBOL_W     = 8,
  parameter int unsigned NUM_RANGES   = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned REPORT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [SYMBOL_W-1:0]           symbols,
  input  logic                          cfg_we,
  input  logic [1:0]                    cfg_kind,
  input  logic [$clog2(NUM_STATES)-1:0] cfg_state,
  input  logic [$clog2(NUM_RANGES)-1:0] cfg_range,
  input  logic [31:0]                   cfg_wdata,
  output logic [NUM_STATES-1:0]         report_now,
  ltl_nfa_if.master                     rpt,
  output logic                          overflow
);
  logic [SYMBOL_W-1:0]   lo [NUM_STATES][NUM_RANGES];
  logic [SYMBOL_W-1:0]   hi [NUM_STATES][NUM_RANGES];
  logic [NUM_STATES-1:0] edge_mask [NUM_STATES];
  logic [NUM_STATES-1:0] report_mask, start_sod, start_all;
  logic [NUM_STATES-1:0] active_q, active_d, enable, match, push_vec;
  logic [CNT_W-1:0]      sym_cnt;
  logic                  sod_pending, start_of_data, push, cfg_hit;
  logic                  unused_cfg;

`ifdef LTL_NFA_ALL_INPUT_EN
  logic [NUM_STATES-1:0] start_all_q;
  assign start_all = start_all_q;
`else
  assign start_all = '0;
`endif

  assign cfg_hit    = cfg_we && (32'(cfg_state) < NUM_STATES)
                             && (32'(cfg_range) < NUM_RANGES);
  assign unused_cfg = ^cfg_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_STATES; i++) begin
        edge_mask[i] <= '0;
        for (int unsigned r = 0; r < NUM_RANGES; r++) begin
          lo[i][r] <= '1;
          hi[i][r] <= '0;
        end
      end
      report_mask <= '0;
      start_sod   <= '0;
`ifdef LTL_NFA_ALL_INPUT_EN
      start_all_q <= '0;
`endif
    end else if (cfg_hit) begin
      case (cfg_kind_e'(cfg_kind))
        CFG_RANGE_LO: lo[cfg_state][cfg_range] <= cfg_wdata[SYMBOL_W-1:0];
        CFG_RANGE_HI: hi[cfg_state][cfg_range] <= cfg_wdata[SYMBOL_W-1:0];
        CFG_EDGE:     edge_mask[cfg_state]     <= cfg_wdata[NUM_STATES-1:0];
        CFG_FLAGS: begin
          report_mask[cfg_state] <= cfg_wdata[FLAG_REPORT];
          start_sod[cfg_state]   <= cfg_wdata[FLAG_START_SOD];
`ifdef LTL_NFA_ALL_INPUT_EN
          start_all_q[cfg_state] <= cfg_wdata[FLAG_START_ALL];
`endif
        end
        default: ;
      endcase
    end
  end

  assign start_of_data = sod_pending & run;

  always_comb begin
    match  = '0;
    enable = '0;
    for (int unsigned i = 0; i < NUM_STATES; i++) begin
      for (int unsigned r = 0; r < NUM_RANGES; r++) begin
        if (symbols >= lo[i][r] && symbols <= hi[i][r]) match[i] = 1'b1;
      end
      enable[i] = (|(active_q & edge_mask[i])) | (start_sod[i] & start_of_data)
                | start_all[i];
    end
    active_d = enable & match;
    push_vec = active_d & report_mask;
    push     = run & (|push_vec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= '0;
      sym_cnt     <= '0;
      sod_pending <= 1'b1;
    end else if (run) begin
      active_q    <= active_d;
      sym_cnt     <= sym_cnt + CNT_W'(1);
      sod_pending <= 1'b0;
    end
  end

  assign report_now = active_q & report_mask;

  ltl_nfa_report_fifo #(
    .DEPTH (REPORT_DEPTH),
    .VEC_W (NUM_STATES),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_idx (sym_cnt),
    .push_vec (push_vec),
    .ready    (rpt.report_ready),
    .valid    (rpt.report_valid),
    .head_idx (rpt.report_idx),
    .head_vec (rpt.report_vec),
    .overflow (overflow)
  );

endmodule
